serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial adder controller that computes a WIDTH-bit sum with a single 1-bit full adder, one bit per clock, LSB first. It latches operands on a start request, steps the full adder through every bit position with a registered carry, and presents the assembled result with a one-cycle done pulse. It serves area-constrained datapaths that can trade latency for a single adder cell.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only while busy=0
- a  in  WIDTH  operand A, latched on accepted start
- b  in  WIDTH  operand B, latched on accepted start
- cin  in  1  carry-in, latched on accepted start
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle pulse when sum/cout become valid
- sum  out  WIDTH  result, registered, held until the next completion
- cout  out  1  carry-out of MSB, registered, held
- ovf  out  1  signed overflow (only with SERIAL_ADDER_OVF_EN)

## Operation
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE: busy=0, done=0. start=1 → load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, go RUN.
- RUN: busy=1. Each cycle, full adder inputs = a_sh[0], b_sh[0], carry. Then a_sh, b_sh shift right; sum bit shifts into the MSB of r_sh (right shift); carry<=full-adder cout; cnt<=cnt+1.
- When cnt==WIDTH-1 in RUN: after that bit, sum<=assembled r_sh, cout<=final carry, go DONE.
- DONE: done=1, busy=0. start=1 → reload as in IDLE and go RUN (back-to-back allowed); else go IDLE.
- start while busy=1 is ignored; operands at the inputs are not re-sampled during RUN.
- cnt width = clog2(WIDTH); no wrap-around beyond WIDTH-1.
- sum/cout change only on completion. They are never written with partial results.
- Reset (any state, including mid-RUN): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal shift registers/carry/cnt=0. The aborted operation produces no done.

## Timing
- Start accepted at rising edge k → busy=1 during cycles k+1 … k+WIDTH.
- Bit i is processed in the cycle following edge k+i; the result registers update at edge k+WIDTH.
- done=1 and sum/cout valid in the cycle after edge k+WIDTH; latency from start to done = WIDTH+1 edges... i.e. done is first seen WIDTH cycles after the accept edge.
- Throughput with back-to-back starts in DONE: one result every WIDTH+1 cycles.
- done is a single-cycle pulse, never asserted together with busy.

## Configuration
- SERIAL_ADDER_OVF_EN defined: port ovf present. ovf = (carry into MSB) XOR (carry out of MSB), captured at edge k+WIDTH alongside cout and held. Reset value 0.
- Undefined: no ovf port and no MSB-carry capture logic. All other behaviour is identical.

## Structure
- Shared package/header: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and default WIDTH constant.
- One sub-module: the existing gate-level full_adder, instantiated once, port order (sum, cout, input1, input2, cin). No other arithmetic in the block.

## Test plan
- WIDTH=8, a=8'h0F, b=8'h01, cin=0 → sum=8'h10, cout=0, done exactly 8 cycles after accept edge, busy high for 8 cycles.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0 (macro on); a=8'h7F, b=8'h01 → sum=8'h80, cout=0, ovf=1.
- a=8'h00, b=8'h00, cin=1 → sum=8'h01, cout=0; a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Accept start with a=8'h05, b=8'h03. During RUN, pulse start with a=8'hAA and change the inputs → ignored; sum=8'h08, only one done.
- Assert rst at bit 4 of an operation → next cycle busy=0, sum=0, cout=0, no done. Then a fresh start 8'h10+8'h20 → sum=8'h30.
- In the done cycle, assert start with a=8'h01, b=8'h02 → busy next cycle. Second done 9 cycles after the first, sum=8'h03. The first result is held until then.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and default width.
package serial_adder_ctrl_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit gate-level full adder; the only arithmetic cell of the serial adder.
module full_adder (
    output logic sum,
    output logic cout,
    input  logic input1,
    input  logic input2,
    input  logic cin
);

    logic half_sum;

    assign half_sum = input1 ^ input2;
    assign sum      = half_sum ^ cin;
    assign cout     = (input1 & input2) | (half_sum & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder step per clock.
// Optional signed-overflow output is built when SERIAL_ADDER_OVF_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | one operand bit per cycle through the full adder
// DONE    | result valid, one-cycle done pulse; start reloads directly
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] r_sh_q, r_sh_d;
    logic [WIDTH-1:0] r_cat;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_sum, fa_cout;
    logic             accept, step, last;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    full_adder u_fa (
        .sum    (fa_sum),
        .cout   (fa_cout),
        .input1 (a_sh_q[0]),
        .input2 (b_sh_q[0]),
        .cin    (carry_q)
    );

    assign last  = (cnt_q == CNT_LAST);
    // Partial result lives in WIDTH-1 bits; the final bit joins it only at completion.
    assign r_cat = {fa_sum, r_sh_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last)  state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        accept = 1'b0;
        step   = 1'b0;
        case (state_q)
            ST_IDLE: accept = start;
            ST_RUN: begin
                busy = 1'b1;
                step = 1'b1;
            end
            ST_DONE: begin
                done   = 1'b1;
                accept = start;
            end
            default: ;
        endcase
    end

    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (accept) begin
            a_sh_d  = a;
            b_sh_d  = b;
            carry_d = cin;
            cnt_d   = '0;
        end else if (step) begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            r_sh_d  = r_cat[WIDTH-1:1];
            carry_d = fa_cout;
            if (last) begin
                sum_d  = r_cat;
                cout_d = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                // carry_q here is the carry into the MSB
                ovf_d  = carry_q ^ fa_cout;
`endif
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
